// File: rtl/rf_write_arbiter_if.sv
// Purpose : bundles the writeback request bus and register-file write port of rf_write_arbiter.
// Latency : none (signal container only).
// Backpr. : req_ready qualifies each requester's req_valid; master = requesters, slave = arbiter.
//
// Signals:
//   hold          master->slave  stall all acceptance this cycle
//   req_valid     master->slave  per-requester write present
//   req_ready     slave->master  per-requester write accepted this cycle
//   req_sel       master->slave  destination register, requester i at [5i+4:5i]
//   req_dat       master->slave  write data, requester i at [32i+31:32i]
//   WEN/wsel/wdat slave->master  registered register-file write port
//   conflict_cnt  slave->master  saturating count of contended cycles
interface rf_write_arbiter_if #(
    parameter int NREQ = 2
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [5*NREQ-1:0]    req_sel;
    logic [32*NREQ-1:0]   req_dat;
    logic                 WEN;
    logic [4:0]           wsel;
    logic [31:0]          wdat;
    logic [15:0]          conflict_cnt;

    modport master (
        output hold,
        output req_valid,
        output req_sel,
        output req_dat,
        input  req_ready,
        input  WEN,
        input  wsel,
        input  wdat,
        input  conflict_cnt
    );

    modport slave (
        input  hold,
        input  req_valid,
        input  req_sel,
        input  req_dat,
        output req_ready,
        output WEN,
        output wsel,
        output wdat,
        output conflict_cnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Purpose : round-robin arbiter of NREQ writeback requesters onto the single register-file write port.
// Latency : transfer at rising edge k drives WEN/wsel/wdat during cycle k+1 (one write per cycle).
// Backpr. : req_ready is combinational from req_valid/hold/ptr; losers and all requesters under hold stall.
//
// Ports:
//   clk    system clock, all state on rising edge
//   n_rst  asynchronous active-low reset; clears a pending write immediately
//   bus    rf_write_arbiter_if.slave (request side and registered write port)
//
// Optional feature: define RF_ARB_ZERO_FILTER_EN to accept sel==0 requests immediately
// without arbitration, pointer movement, conflict counting or a register-file write.
module rf_write_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    rf_write_arbiter_if.slave     bus
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]   r_ptr;
    logic            r_wen;
    logic [4:0]      r_wsel;
    logic [31:0]     r_wdat;
    logic [15:0]     r_conflict_cnt;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] w_zero_acc;   // sel==0 requests accepted outside arbitration
    logic [NREQ-1:0] w_cont;       // contenders for the write port
    logic [2:0]      w_ncont;
    logic            w_gnt_vld;
    logic [PW-1:0]   w_gnt;
    logic [NREQ-1:0] w_gnt_oh;
    logic [4:0]      w_gnt_sel;
    logic [31:0]     w_gnt_dat;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_ready;
    logic            w_active;     // arbitration allowed this cycle

    assign w_active = n_rst && !bus.hold;

`ifdef RF_ARB_ZERO_FILTER_EN
    // Writes to register 0 have no architectural effect, so they are
    // absorbed immediately and never occupy the write port.
    always_comb begin
        w_zero_acc = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_zero_acc[i] = bus.req_valid[i] && (bus.req_sel[5*i +: 5] == 5'd0);
        end
    end
`else
    assign w_zero_acc = '0;
`endif

    assign w_cont = bus.req_valid & ~w_zero_acc;

    always_comb begin
        w_ncont = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ncont = w_ncont + 3'(w_cont[i]);
        end
    end

    // Scan ptr, ptr+1, ... (mod NREQ) and take the first contender.
    always_comb begin : arb_scan
        logic [PW:0] v_sum;
        logic [PW:0] v_idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        v_sum     = '0;
        v_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_sum = {1'b0, r_ptr} + (PW+1)'(k);
            v_idx = (v_sum >= (PW+1)'(NREQ)) ? (v_sum - (PW+1)'(NREQ)) : v_sum;
            if (!w_gnt_vld && w_cont[v_idx[PW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = v_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_oh  = '0;
        w_gnt_sel = '0;
        w_gnt_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == PW'(i)) begin
                w_gnt_oh[i] = w_gnt_vld;
                w_gnt_sel   = bus.req_sel[5*i +: 5];
                w_gnt_dat   = bus.req_dat[32*i +: 32];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == PW'(NREQ-1)) ? '0 : (w_gnt + PW'(1));

    // hold and reset both block every acceptance, including zero-sel ones.
    assign w_ready       = w_active ? (w_gnt_oh | w_zero_acc) : '0;
    assign bus.req_ready = w_ready;

    // ------------------------------------------------------------------
    // Registered write port, pointer and contention counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr          <= '0;
            r_wen          <= 1'b0;
            r_wsel         <= '0;
            r_wdat         <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_wen <= w_active && w_gnt_vld;
            if (w_active && w_gnt_vld) begin
                r_wsel <= w_gnt_sel;
                r_wdat <= w_gnt_dat;
                r_ptr  <= w_ptr_nxt;
            end
            if (w_active && (w_ncont >= 3'd2) && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign bus.WEN          = r_wen;
    assign bus.wsel         = r_wsel;
    assign bus.wdat         = r_wdat;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose : directed self-checking bench for rf_write_arbiter with NREQ=2 and a register-file model.
// Latency : steps advance one rising edge; outputs sampled 1 time unit after the edge.
// Backpr. : requesters hold valid/sel/dat until ready is observed, as the protocol requires.
module tb_rf_write_arbiter;
    logic clk;
    logic n_rst;
    int   checks;
    int   errors;

    rf_write_arbiter_if #(.NREQ(2)) bus ();

    rf_write_arbiter #(.NREQ(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: commits on the falling edge in the middle of the WEN cycle.
    logic [31:0] rf [32];
    logic        rf_init;
    always @(negedge clk) begin
        if (rf_init) begin
            for (int j = 0; j < 32; j++) rf[j] <= 32'd0;
        end else if (bus.WEN && bus.wsel != 5'd0) begin
            rf[bus.wsel] <= bus.wdat;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        n_rst         = 1'b0;
        rf_init       = 1'b1;
        bus.hold      = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_sel   = '0;
        bus.req_dat   = '0;

        // Reset: no acceptance even with valid requests present.
        step();
        chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
        chk("wen_in_reset", 32'(bus.WEN), 32'h0);
        bus.req_valid = 2'b00;
        step();
        rf_init = 1'b0;
        n_rst   = 1'b1;
        step();
        chk("idle_wen", 32'(bus.WEN), 32'h0);
        chk("idle_wsel", 32'(bus.wsel), 32'h0);
        chk("idle_wdat", bus.wdat, 32'h0);
        chk("idle_cnt", 32'(bus.conflict_cnt), 32'h0);
        chk("idle_ready", 32'(bus.req_ready), 32'h0);

        // Single request from requester 0 (ptr 0 -> 1).
        bus.req_sel   = {5'd0, 5'd5};
        bus.req_dat   = {32'h0, 32'hDEADBEEF};
        bus.req_valid = 2'b01;
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        chk("single_wen", 32'(bus.WEN), 32'h1);
        chk("single_wsel", 32'(bus.wsel), 32'h5);
        chk("single_wdat", bus.wdat, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("rf5_read", rf[5], 32'hDEADBEEF);
        step();
        chk("single_wen_off", 32'(bus.WEN), 32'h0);
        chk("single_wsel_hold", 32'(bus.wsel), 32'h5);
        chk("single_cnt", 32'(bus.conflict_cnt), 32'h0);

        // Contention: ptr=1, so grants go 1,0,1,0 on four consecutive edges.
        bus.req_sel   = {5'd2, 5'd1};
        bus.req_dat   = {32'hB1B1B1B1, 32'hA0A0A0A0};
        bus.req_valid = 2'b11;
        #1;
        chk("cont0_ready", 32'(bus.req_ready), 32'h2);
        step();
        chk("cont0_wen", 32'(bus.WEN), 32'h1);
        chk("cont0_wsel", 32'(bus.wsel), 32'h2);
        chk("cont1_ready", 32'(bus.req_ready), 32'h1);
        step();
        chk("cont1_wen", 32'(bus.WEN), 32'h1);
        chk("cont1_wdat", bus.wdat, 32'hA0A0A0A0);
        chk("cont2_ready", 32'(bus.req_ready), 32'h2);
        step();
        chk("cont2_wen", 32'(bus.WEN), 32'h1);
        chk("cont2_wsel", 32'(bus.wsel), 32'h2);
        chk("cont3_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        chk("cont3_wen", 32'(bus.WEN), 32'h1);
        chk("cont3_wsel", 32'(bus.wsel), 32'h1);
        chk("cont_cnt", 32'(bus.conflict_cnt), 32'h4);

        // hold for two cycles: nothing accepted, nothing counted, ptr stays 1.
        bus.hold      = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("hold_ready", 32'(bus.req_ready), 32'h0);
        step();
        chk("hold1_wen", 32'(bus.WEN), 32'h0);
        step();
        chk("hold2_wen", 32'(bus.WEN), 32'h0);
        chk("hold_cnt", 32'(bus.conflict_cnt), 32'h4);
        bus.hold = 1'b0;
        #1;
        chk("post_hold_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 2'b00;
        chk("post_hold_wen", 32'(bus.WEN), 32'h1);
        chk("post_hold_wsel", 32'(bus.wsel), 32'h2);
        chk("post_hold_cnt", 32'(bus.conflict_cnt), 32'h5);

        // Zero-sel request from requester 0 alongside sel=7 from requester 1; ptr=0.
        bus.req_sel   = {5'd7, 5'd0};
        bus.req_dat   = {32'h77777777, 32'h11111111};
        bus.req_valid = 2'b11;
        #1;
`ifdef RF_ARB_ZERO_FILTER_EN
        chk("zf_ready", 32'(bus.req_ready), 32'h3);
        step();
        bus.req_valid = 2'b00;
        chk("zf_wen", 32'(bus.WEN), 32'h1);
        chk("zf_wsel", 32'(bus.wsel), 32'h7);
        chk("zf_cnt", 32'(bus.conflict_cnt), 32'h5);
        step();
        chk("zf_wen_off", 32'(bus.WEN), 32'h0);
`else
        chk("z0_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b10;
        chk("z0_wen", 32'(bus.WEN), 32'h1);
        chk("z0_wsel", 32'(bus.wsel), 32'h0);
        chk("z0_cnt", 32'(bus.conflict_cnt), 32'h6);
        #1;
        chk("z1_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 2'b00;
        chk("z1_wen", 32'(bus.WEN), 32'h1);
        chk("z1_wsel", 32'(bus.wsel), 32'h7);
        chk("z1_cnt", 32'(bus.conflict_cnt), 32'h6);
`endif

        // Reset in the cycle after a grant: the pending write never commits.
        bus.req_sel   = {5'd0, 5'd9};
        bus.req_dat   = {32'h0, 32'hCAFEF00D};
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        chk("rst_pre_wen", 32'(bus.WEN), 32'h1);
        n_rst = 1'b0;
        #1;
        chk("rst_async_wen", 32'(bus.WEN), 32'h0);
        chk("rst_async_cnt", 32'(bus.conflict_cnt), 32'h0);
        @(negedge clk);
        #1;
        chk("rf9_untouched", rf[9], 32'h0);
        step();
        n_rst = 1'b1;
        step();
        chk("rst_after_wen", 32'(bus.WEN), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates several writeback requesters (e.g. ALU result, load data, multiply/divide unit) onto the single write port of the 32x32 register file. Uses round-robin fairness and valid/ready handshakes. The granted write is registered, so the register file sees a clean, glitch-free WEN/wsel/wdat for a full cycle and commits it on the falling edge. Also keeps a saturating contention counter for performance analysis.

## Interface
- NREQ, 2, number of requesters; legal range 2..4
- clk  in  1  system clock; all state updates on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- hold  in  1  when 1, no request is accepted this cycle
- req_valid  in  NREQ  bit i: requester i presents a write
- req_ready  out  NREQ  bit i: requester i's write is accepted this cycle
- req_sel  in  5*NREQ  destination register; requester i at [5i+4:5i]
- req_dat  in  32*NREQ  write data; requester i at [32i+31:32i]
- WEN  out  1  register-file write enable (registered)
- wsel  out  5  register-file write select (registered)
- wdat  out  32  register-file write data (registered)
- conflict_cnt  out  16  cycles with two or more contending requests; saturating

## Operation
- Transfer on requester i: req_valid[i] && req_ready[i] at a rising edge.
- Requesters hold valid, sel and dat stable until the transfer.
- req_ready is combinational from req_valid, hold and the internal pointer. It must not feed back into req_valid.
- Contender: requester with req_valid=1, subject to the zero filter (see Configuration).
- Round-robin pointer ptr, range 0..NREQ-1.
  - Grant g is the first contender found scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[g]=1; all other contenders get ready=0.
  - After a grant, ptr <= (g+1) mod NREQ. With no grant, ptr is unchanged.
- Output register at each rising edge:
  - If a contender was granted: WEN<=1, wsel<=req_sel[g], wdat<=req_dat[g].
  - Otherwise: WEN<=0, and wsel/wdat hold their previous values.
- hold=1: every req_ready=0 (including zero-filter acceptance); next WEN=0; ptr and conflict_cnt unchanged.
- conflict_cnt:
  - Increments when hold=0 and at least two contenders are present.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- At most one register-file write per cycle. Losing requesters stall with valid held; a loser is guaranteed a grant within NREQ-1 grant cycles.

## Timing
- Reset values: WEN=0, wsel=0, wdat=0, conflict_cnt=0, ptr=0.
- req_ready is 0 for all requesters while n_rst=0.
- Latency: a transfer at rising edge k drives WEN/wsel/wdat during cycle k+1.
  - The register file commits at the falling edge in the middle of cycle k+1.
  - Read ports return the new value from that falling edge onward.
- Back-to-back transfers on consecutive edges give WEN=1 on consecutive cycles, so throughput is one write per cycle.
- Reset asserted mid-operation: a pending registered write is discarded (WEN forced to 0 asynchronously); no write reaches the register file.
- A requester dropping valid without a transfer is a protocol violation; the result is undefined.

## Configuration
- Macro RF_ARB_ZERO_FILTER_EN.
- Defined:
  - A valid request with sel==0 is accepted immediately (ready=1 when hold=0), regardless of the pointer, and is not a contender.
  - It does not move ptr, does not count toward conflict_cnt, and produces no WEN.
  - Several zero-sel requests can be accepted in the same cycle alongside one normal grant.
- Undefined: sel==0 requests arbitrate like any other and drive WEN=1, wsel=0 (harmless, since register 0 reads as zero).

## Test plan
- Reset, then idle: after n_rst rises, WEN=0, wsel=0, wdat=0, conflict_cnt=0, req_ready=0.
- Single request: req 0 valid, sel=5, dat=32'hDEADBEEF at edge k -> ready[0]=1 before edge k; WEN=1, wsel=5, wdat=DEADBEEF in cycle k+1; a read of register 5 returns DEADBEEF after that falling edge.
- Contention, NREQ=2: both valid and held for 4 cycles -> grants alternate 0,1,0,1; WEN=1 in four consecutive cycles; conflict_cnt=4.
- hold=1 for 2 cycles with both valid -> ready=0, WEN=0, ptr and conflict_cnt unchanged; after hold drops, the next grant goes to the requester ptr selects.
- With RF_ARB_ZERO_FILTER_EN: req 0 sel=0 and req 1 sel=7 valid together -> both ready=1 the same cycle; next cycle WEN=1, wsel=7; conflict_cnt unchanged. Without the macro: two cycles of WEN=1 (wsel=0, then wsel=7, or the reverse per ptr) and conflict_cnt increments by 1.
- Reset mid-write: assert n_rst=0 in the cycle after a grant -> WEN drops to 0 immediately and the target register stays 0.
